// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions: geometry, entry type codes, per-entry metadata.
package rob_pkg;
  localparam int ROB_BIT  = 3;
  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam int XLEN     = 32;

  typedef enum logic [1:0] {
    ROB_REG  = 2'b00,
    ROB_BR   = 2'b01,
    ROB_ST   = 2'b10,
    ROB_EXIT = 2'b11
  } rob_type_e;

  // Static per-entry info captured at allocation time.
  typedef struct packed {
    rob_type_e        typ;
    logic [4:0]       rd;
    logic             pred;
    logic [XLEN-1:0]  alt_pc;
  } rob_meta_t;

  // Stores and EXIT have nothing to wait for, so they are complete at issue.
  function automatic logic ready_at_issue(input rob_type_e t);
    return (t == ROB_ST) || (t == ROB_EXIT);
  endfunction
endpackage

// File: rtl/rob_fwd_mux.sv
// Operand lookup for one decoder query: stored result first, then same-cycle
// LSB broadcast, then same-cycle RS broadcast.
module rob_fwd_mux
  import rob_pkg::*;
(
  input  logic [ROB_BIT-1:0]             i_qry,
  input  logic [ROB_SIZE-1:0]            i_busy,
  input  logic [ROB_SIZE-1:0]            i_ready,
  input  logic [ROB_SIZE-1:0][XLEN-1:0]  i_value,
  input  logic                           i_rs_ready,
  input  logic [ROB_BIT-1:0]             i_rs_entry,
  input  logic [XLEN-1:0]                i_rs_value,
  input  logic                           i_lsb_ready,
  input  logic [ROB_BIT-1:0]             i_lsb_entry,
  input  logic [XLEN-1:0]                i_lsb_value,
  output logic                           o_ready,
  output logic [XLEN-1:0]                o_value
);
  // Priority select; broadcasts only count when they hit a live entry.
  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (i_ready[i_qry]) begin
      o_ready = 1'b1;
      o_value = i_value[i_qry];
    end else if (i_lsb_ready && i_lsb_entry == i_qry && i_busy[i_qry]) begin
      o_ready = 1'b1;
      o_value = i_lsb_value;
    end else if (i_rs_ready && i_rs_entry == i_qry && i_busy[i_qry]) begin
      o_ready = 1'b1;
      o_value = i_rs_value;
    end
  end
endmodule

// File: rtl/rob.sv
// Reorder buffer: circular tag allocator, result collector and in-order
// committer with branch-mispredict flush and EXIT halt.
module rob
  import rob_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_signal,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic                issue_pred_taken,
  input  logic [XLEN-1:0]     issue_alt_pc,
  output logic [ROB_BIT-1:0]  issue_entry,
  output logic                is_full,
  input  logic                rs_ready,
  input  logic [ROB_BIT-1:0]  rs_rob_entry,
  input  logic [XLEN-1:0]     rs_value,
  input  logic                lsb_ready,
  input  logic [ROB_BIT-1:0]  lsb_rob_entry,
  input  logic [XLEN-1:0]     lsb_value,
  input  logic [ROB_BIT-1:0]  qry1_entry,
  input  logic [ROB_BIT-1:0]  qry2_entry,
  output logic                qry1_ready,
  output logic                qry2_ready,
  output logic [XLEN-1:0]     qry1_value,
  output logic [XLEN-1:0]     qry2_value,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [XLEN-1:0]     commit_value,
  output logic [ROB_BIT-1:0]  commit_entry,
  output logic                commit_store,
  output logic                rob_clear_up,
  output logic [XLEN-1:0]     clear_pc,
  output logic                halt_out
);
  localparam logic [ROB_BIT:0] FULL_CNT = (ROB_BIT+1)'(ROB_SIZE);

  logic [ROB_BIT-1:0]            r_head, r_tail;
  logic [ROB_BIT:0]              r_count;
  logic [ROB_SIZE-1:0]           r_busy, r_ready;
  logic [ROB_SIZE-1:0][XLEN-1:0] r_value;
  rob_meta_t                     r_meta [ROB_SIZE];

  logic      w_full, w_commit, w_flush, w_alloc;
  rob_meta_t w_hmeta;
  rob_type_e w_itype;

  assign w_full   = (r_count == FULL_CNT);
  assign w_hmeta  = r_meta[r_head];
  assign w_itype  = rob_type_e'(issue_type);
  // Once halted nothing else leaves the buffer until reset.
  assign w_commit = r_busy[r_head] && r_ready[r_head] && !halt_out;
  assign w_flush  = w_commit && (w_hmeta.typ == ROB_BR) &&
                    (r_value[r_head][0] != w_hmeta.pred);
  // An issue in the flushing cycle belongs to the wrong path.
  assign w_alloc  = issue_signal && !w_full && !w_flush;

  assign issue_entry = r_tail;
  assign is_full     = w_full;

  // Entry storage: writeback (LSB overrides RS), commit release, allocation, flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy  <= '0;
      r_ready <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (rs_ready && rs_rob_entry == ROB_BIT'(i) && r_busy[i]) begin
          r_ready[i] <= 1'b1;
          r_value[i] <= rs_value;
        end
        if (lsb_ready && lsb_rob_entry == ROB_BIT'(i) && r_busy[i]) begin
          r_ready[i] <= 1'b1;
          r_value[i] <= lsb_value;
        end
      end
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= ready_at_issue(w_itype);
        r_value[r_tail] <= '0;
        r_meta[r_tail]  <= '{typ: w_itype, rd: issue_rd,
                             pred: issue_pred_taken, alt_pc: issue_alt_pc};
      end
      if (w_flush) begin
        r_busy  <= '0;
        r_ready <= '0;
      end
    end
  end

  // Pointers, occupancy and registered commit / flush / halt outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_entry <= '0;
      commit_store <= 1'b0;
      rob_clear_up <= 1'b0;
      clear_pc     <= '0;
      halt_out     <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      rob_clear_up <= 1'b0;
      if (rdy_in) begin
        if (w_commit) begin
          commit_valid <= 1'b1;
          commit_rd    <= (w_hmeta.typ == ROB_REG) ? w_hmeta.rd : 5'd0;
          commit_value <= r_value[r_head];
          commit_entry <= r_head;
          commit_store <= (w_hmeta.typ == ROB_ST);
          if (w_hmeta.typ == ROB_EXIT) halt_out <= 1'b1;
        end
        if (w_flush) begin
          rob_clear_up <= 1'b1;
          clear_pc     <= w_hmeta.alt_pc;
          r_head       <= '0;
          r_tail       <= '0;
          r_count      <= '0;
        end else begin
          if (w_commit) r_head <= r_head + ROB_BIT'(1);
          if (w_alloc)  r_tail <= r_tail + ROB_BIT'(1);
          case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  end

  rob_fwd_mux u_fwd1 (
    .i_qry(qry1_entry), .i_busy(r_busy), .i_ready(r_ready), .i_value(r_value),
    .i_rs_ready(rs_ready), .i_rs_entry(rs_rob_entry), .i_rs_value(rs_value),
    .i_lsb_ready(lsb_ready), .i_lsb_entry(lsb_rob_entry), .i_lsb_value(lsb_value),
    .o_ready(qry1_ready), .o_value(qry1_value)
  );

  rob_fwd_mux u_fwd2 (
    .i_qry(qry2_entry), .i_busy(r_busy), .i_ready(r_ready), .i_value(r_value),
    .i_rs_ready(rs_ready), .i_rs_entry(rs_rob_entry), .i_rs_value(rs_value),
    .i_lsb_ready(lsb_ready), .i_lsb_entry(lsb_rob_entry), .i_lsb_value(lsb_value),
    .o_ready(qry2_ready), .o_value(qry2_value)
  );
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus random traffic, all checked against a
// program-order queue model of the buffer.
module tb_rob;
  logic        clk_in = 1'b0, rst_in, rdy_in;
  logic        issue_signal, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic [2:0]  issue_entry;
  logic        is_full;
  logic        rs_ready, lsb_ready;
  logic [2:0]  rs_rob_entry, lsb_rob_entry, qry1_entry, qry2_entry;
  logic [31:0] rs_value, lsb_value, qry1_value, qry2_value;
  logic        qry1_ready, qry2_ready;
  logic        commit_valid, commit_store, rob_clear_up, halt_out;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, clear_pc;
  logic [2:0]  commit_entry;

  always #5 clk_in = ~clk_in;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_signal(issue_signal), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .issue_entry(issue_entry), .is_full(is_full),
    .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .qry1_entry(qry1_entry), .qry2_entry(qry2_entry),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_value(qry1_value), .qry2_value(qry2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_entry(commit_entry), .commit_store(commit_store),
    .rob_clear_up(rob_clear_up), .clear_pc(clear_pc), .halt_out(halt_out)
  );

  int n_chk = 0, n_err = 0;

  // Model: tags in program order, per-tag info, next tag to hand out.
  int          q[$];
  bit          m_ready [8];
  logic [31:0] m_val   [8];
  logic [1:0]  m_type  [8];
  logic [4:0]  m_rd    [8];
  bit          m_pred  [8];
  logic [31:0] m_alt   [8];
  int          m_tail = 0;
  bit          m_halt = 0;
  bit          e_cv, e_st, e_clr;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_cpc;
  logic [2:0]  e_ent;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit live(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic exp_qry(input int t, output bit r, output logic [31:0] v);
    r = 1'b0; v = '0;
    if (live(t) && m_ready[t])                               begin r = 1'b1; v = m_val[t]; end
    else if (lsb_ready && int'(lsb_rob_entry) == t && live(t)) begin r = 1'b1; v = lsb_value; end
    else if (rs_ready && int'(rs_rob_entry) == t && live(t))   begin r = 1'b1; v = rs_value; end
  endtask

  task automatic model_reset();
    q.delete(); m_tail = 0; m_halt = 0;
    e_cv = 0; e_st = 0; e_clr = 0; e_rd = 0; e_val = 0; e_cpc = 0; e_ent = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    bit r; logic [31:0] v;
    bit full, com, flush;
    int h;
    #1;
    full = (q.size() == 8);
    chk("issue_entry", issue_entry, m_tail);
    chk("is_full", is_full, full);
    exp_qry(qry1_entry, r, v);
    chk("qry1_ready", qry1_ready, r); chk("qry1_value", qry1_value, v);
    exp_qry(qry2_entry, r, v);
    chk("qry2_ready", qry2_ready, r); chk("qry2_value", qry2_value, v);

    e_cv = 0; e_st = 0; e_clr = 0;
    if (rst_in) model_reset();
    else if (rdy_in) begin
      com = (q.size() > 0) && m_ready[q[0]] && !m_halt;
      h = com ? q[0] : 0;
      flush = 0;
      if (com) begin
        e_cv = 1; e_ent = 3'(h); e_val = m_val[h];
        e_rd = (m_type[h] == 2'b00) ? m_rd[h] : 5'd0;
        e_st = (m_type[h] == 2'b10);
        if (m_type[h] == 2'b11) m_halt = 1;
        flush = (m_type[h] == 2'b01) && (m_val[h][0] != m_pred[h]);
      end
      if (rs_ready && live(rs_rob_entry))   begin m_ready[rs_rob_entry] = 1;  m_val[rs_rob_entry] = rs_value; end
      if (lsb_ready && live(lsb_rob_entry)) begin m_ready[lsb_rob_entry] = 1; m_val[lsb_rob_entry] = lsb_value; end
      if (com) void'(q.pop_front());
      if (flush) begin
        q.delete(); m_tail = 0; e_clr = 1; e_cpc = m_alt[h];
      end
      if (issue_signal && !full && !flush) begin
        q.push_back(m_tail);
        m_type[m_tail] = issue_type; m_rd[m_tail] = issue_rd;
        m_pred[m_tail] = issue_pred_taken; m_alt[m_tail] = issue_alt_pc;
        m_ready[m_tail] = (issue_type == 2'b10) || (issue_type == 2'b11);
        m_val[m_tail] = '0;
        m_tail = (m_tail + 1) % 8;
      end
    end

    @(posedge clk_in); #1;
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_value", commit_value, e_val);
    chk("commit_entry", commit_entry, e_ent);
    chk("commit_store", commit_store, e_st);
    chk("rob_clear_up", rob_clear_up, e_clr);
    chk("clear_pc", clear_pc, e_cpc);
    chk("halt_out", halt_out, m_halt);
    @(negedge clk_in);
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; issue_signal = 0; issue_type = 0; issue_rd = 0;
    issue_pred_taken = 0; issue_alt_pc = 0;
    rs_ready = 0; rs_rob_entry = 0; rs_value = 0;
    lsb_ready = 0; lsb_rob_entry = 0; lsb_value = 0;
    qry1_entry = 0; qry2_entry = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                       input bit pred, input logic [31:0] alt);
    idle(); issue_signal = 1; issue_type = t; issue_rd = rd;
    issue_pred_taken = pred; issue_alt_pc = alt;
    step();
  endtask

  task automatic do_reset();
    idle(); rst_in = 1; step(); rst_in = 0;
  endtask

  initial begin
    idle(); rst_in = 1;
    model_reset();
    @(negedge clk_in); @(negedge clk_in);
    do_reset();

    // Fill: eight REG issues, ninth ignored while full.
    for (int i = 0; i < 9; i++) issue(2'b00, 5'(i + 1), 0, 0);
    chk("fill_full", is_full, 1'b1);
    chk("fill_tail", issue_entry, 3'd0);
    do_reset();

    // Out-of-order writeback, in-order commit.
    issue(2'b00, 5'd3, 0, 0);
    issue(2'b00, 5'd4, 0, 0);
    idle(); rs_ready = 1; rs_rob_entry = 1; rs_value = 5; step();
    idle(); lsb_ready = 1; lsb_rob_entry = 0; lsb_value = 9; step();
    repeat (3) begin idle(); step(); end

    // Same-cycle forwarding to a query.
    do_reset();
    repeat (3) issue(2'b00, 5'd7, 0, 0);
    idle(); qry1_entry = 2; qry2_entry = 1;
    rs_ready = 1; rs_rob_entry = 2; rs_value = 32'h1234;
    lsb_ready = 1; lsb_rob_entry = 1; lsb_value = 32'hBEEF;
    step();
    idle(); qry1_entry = 2; qry2_entry = 1;
    rs_ready = 1; rs_rob_entry = 1; rs_value = 32'h7777;
    lsb_ready = 1; lsb_rob_entry = 1; lsb_value = 32'h8888;
    step();

    // Mispredicted branch flushes younger REG entries.
    do_reset();
    issue(2'b01, 5'd9, 0, 32'h100);
    repeat (3) issue(2'b00, 5'd2, 0, 0);
    idle(); rs_ready = 1; rs_rob_entry = 0; rs_value = 1; step();
    repeat (3) begin idle(); step(); end

    // Correct branch then store: no flush.
    issue(2'b01, 5'd9, 1, 32'h200);
    idle(); rs_ready = 1; rs_rob_entry = 0; rs_value = 1; issue_signal = 1; issue_type = 2'b10; step();
    repeat (3) begin idle(); step(); end

    // Steady issue+commit with four in flight across pointer wrap.
    do_reset();
    repeat (4) issue(2'b00, 5'd5, 0, 0);
    idle(); rs_ready = 1; rs_rob_entry = 3'(q[0]); rs_value = $urandom; step();
    for (int i = 0; i < 20; i++) begin
      idle(); issue_signal = 1; issue_rd = 5'(i);
      rs_ready = 1; rs_rob_entry = 3'(q[1]); rs_value = $urandom;
      step();
      chk("steady_count", q.size(), 4);
    end

    // Pause: nothing moves while rdy_in is low.
    idle(); rdy_in = 0; issue_signal = 1; rs_ready = 1; rs_rob_entry = 3'(q[1]); step();
    idle(); rdy_in = 0; step();

    // Reset with five entries busy.
    do_reset();
    repeat (5) issue(2'b00, 5'd1, 0, 0);
    do_reset();
    chk("rst_full", is_full, 1'b0);
    chk("rst_entry", issue_entry, 3'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      rdy_in = ($urandom_range(9) != 0);
      issue_signal = 1'($urandom_range(1));
      r = $urandom_range(9);
      issue_type = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'b10;
      issue_rd = 5'($urandom); issue_pred_taken = 1'($urandom); issue_alt_pc = $urandom;
      rs_ready = 1'($urandom); rs_rob_entry = 3'($urandom); rs_value = $urandom;
      lsb_ready = 1'($urandom); lsb_rob_entry = 3'($urandom); lsb_value = $urandom;
      qry1_entry = 3'($urandom); qry2_entry = 3'($urandom);
      step();
    end

    // EXIT halts commit; a ready store behind it stays put.
    do_reset();
    issue(2'b11, 5'd1, 0, 0);
    issue(2'b10, 5'd1, 0, 0);
    repeat (3) begin idle(); step(); end
    chk("halt_sticky", halt_out, 1'b1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
